wb_regfile_hilo: RTL and testbench
==================================

# wb_regfile_hilo

Architectural state at the end of the pipeline: 32×32-bit general-purpose register file plus HI/LO special registers. Consumes the write-back bundle registered by the MEM/WB pipeline register. Serves two GPR read ports to the decode stage and the HI/LO read port to the execute stage. Provides same-cycle write-to-read bypass so that no separate WB-stage forwarding path is needed.

## Interface
Parameters:
- DATA_W, 32, width of every register and data port
- ADDR_W, 5, GPR address width; register count = 2**ADDR_W

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- we  in  1  GPR write enable (wb_wreg)
- waddr  in  ADDR_W  GPR write address (wb_wd)
- wdata  in  DATA_W  GPR write data (wb_wdata)
- whilo  in  1  HI/LO write enable (wb_whilo)
- hi_i  in  DATA_W  HI write data (wb_hi)
- lo_i  in  DATA_W  LO write data (wb_lo)
- re1  in  1  read port 1 enable
- raddr1  in  ADDR_W  read port 1 address
- rdata1  out  DATA_W  read port 1 data
- re2  in  1  read port 2 enable
- raddr2  in  ADDR_W  read port 2 address
- rdata2  out  DATA_W  read port 2 data
- hi_o  out  DATA_W  current HI (bypassed)
- lo_o  out  DATA_W  current LO (bypassed)

## Operation
- GPR write: at rising edge, if !rst && we && waddr != 0, regs[waddr] <= wdata.
- Register 0 is hardwired zero: writes to address 0 are dropped; reads of address 0 return 0 regardless of bypass.
- HI/LO write: at rising edge, if !rst && whilo, hi <= hi_i and lo <= lo_i. HI and LO are always written together.
- Read port n (combinational), evaluated in priority order:
  - rst high -> 0
  - raddrn == 0 -> 0
  - ren && we && raddrn == waddr -> wdata (bypass)
  - ren -> regs[raddrn]
  - otherwise -> 0
- Both read ports are independent. Same address on both ports returns identical data.
- HI/LO read: rst high -> 0. Otherwise whilo ? hi_i/lo_i : hi/lo.
- Reset: all 32 GPRs, HI and LO are cleared to 0 on the first rising edge with rst high.
- While rst is high, every output reads 0 and all write requests are ignored.

## Timing
- Write latency: data presented in cycle N is stored at the end of cycle N. Through the bypass it is visible on the read outputs during cycle N itself.
- Read latency: 0 cycles, purely combinational from address/enable to data.
- Reset values of outputs: rdata1, rdata2, hi_o and lo_o are all 0.
- Reset mid-stream: a write asserted in the same cycle as rst is lost. On the cycle after rst deasserts, all registers read 0.
- Simultaneous GPR write and HI/LO write are independent and both commit.
- No stall or handshake: the block accepts one GPR write and one HI/LO write every cycle.

## Structure
- Shared definitions in defines.v, not local literals: RegBus, RegAddrBus, ZeroWord, NOPRegAddr, WriteEnable/WriteDisable, ReadEnable/ReadDisable, RstEnable.
- One sub-module: hilo_reg. It holds HI/LO storage, write and bypass, and is instantiated once.
- GPR array, the two read-port muxes and the $zero handling stay in the top module.

## Test plan
- Reset: hold rst for 2 cycles after writing 0xDEADBEEF to r5. Read r5 after release -> 0. hi_o = lo_o = 0.
- Basic write/read: write r3 = 0x12345678 in cycle N. Read r3 on port 1 in cycle N+1 -> 0x12345678. Port 2 reading r4 -> 0.
- Bypass: in the same cycle, write r7 = 0xA5A5A5A5 and read r7 on both ports with re=1 -> both outputs 0xA5A5A5A5. With re1=0 -> rdata1 = 0.
- $zero: write r0 = 0xFFFFFFFF. Same-cycle read -> 0. Next-cycle read -> 0.
- HI/LO: whilo=1, hi_i=0x1, lo_i=0x2 -> hi_o/lo_o = 1/2 in the same cycle and persist after whilo drops. A following whilo=1 with 0x3/0x4 -> 3/4 immediately.
- Simultaneous activity: one cycle with we=1 to r31 = 0x55, whilo=1, and rst asserted -> nothing commits. Outputs read 0 in that cycle and after rst release.

Source files
------------

// File: rtl/wb_regfile_hilo_pkg.sv
// Shared constants for the write-back register file: bus widths, zero word,
// null register address and the polarity of enable/reset strobes.
package wb_regfile_hilo_pkg;

    // Bus widths
    localparam int REG_BUS_W      = 32;
    localparam int REG_ADDR_BUS_W = 5;
    localparam int REG_NUM        = 2 ** REG_ADDR_BUS_W;

    // Canonical values
    localparam logic [REG_BUS_W-1:0]      ZERO_WORD    = '0;
    localparam logic [REG_ADDR_BUS_W-1:0] NOP_REG_ADDR = '0;

    // Strobe polarities
    localparam logic WRITE_ENABLE  = 1'b1;
    localparam logic WRITE_DISABLE = 1'b0;
    localparam logic READ_ENABLE   = 1'b1;
    localparam logic READ_DISABLE  = 1'b0;
    localparam logic RST_ENABLE    = 1'b1;

endpackage : wb_regfile_hilo_pkg

// File: rtl/wb_regfile_hilo_hilo_reg.sv
// HI/LO special-register pair. Both halves are always written together, and
// a write in flight is bypassed straight to the outputs in the same cycle.
module hilo_reg
    import wb_regfile_hilo_pkg::*;
#(
    parameter int DATA_W = REG_BUS_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              whilo,
    input  logic [DATA_W-1:0] hi_i,
    input  logic [DATA_W-1:0] lo_i,
    output logic [DATA_W-1:0] hi_o,
    output logic [DATA_W-1:0] lo_o
);

    logic [DATA_W-1:0] hi_q, hi_d;
    logic [DATA_W-1:0] lo_q, lo_d;

    // Next-state: take the incoming pair when the write strobe is up.
    always_comb begin
        hi_d = hi_q;
        lo_d = lo_q;
        if (whilo == WRITE_ENABLE) begin
            hi_d = hi_i;
            lo_d = lo_i;
        end
    end

    // Storage: synchronous clear wins over any write in the same cycle.
    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE) begin
            hi_q <= DATA_W'(ZERO_WORD);
            lo_q <= DATA_W'(ZERO_WORD);
        end else begin
            hi_q <= hi_d;
            lo_q <= lo_d;
        end
    end

    // Read side: zero under reset, otherwise bypass the pending write.
    always_comb begin
        hi_o = DATA_W'(ZERO_WORD);
        lo_o = DATA_W'(ZERO_WORD);
        if (rst != RST_ENABLE) begin
            if (whilo == WRITE_ENABLE) begin
                hi_o = hi_i;
                lo_o = lo_i;
            end else begin
                hi_o = hi_q;
                lo_o = lo_q;
            end
        end
    end

endmodule : hilo_reg

// File: rtl/wb_regfile_hilo.sv
// Architectural register state: 32 GPRs with hardwired $zero, two
// combinational read ports with same-cycle write bypass, and the HI/LO pair.
// There is no handshake: one GPR write and one HI/LO write are accepted
// every cycle, and reads return data in the cycle the address is presented.
module wb_regfile_hilo
    import wb_regfile_hilo_pkg::*;
#(
    parameter int DATA_W = REG_BUS_W,
    parameter int ADDR_W = REG_ADDR_BUS_W
) (
    input  logic              clk,
    input  logic              rst,
    // Write-back bundle
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              whilo,
    input  logic [DATA_W-1:0] hi_i,
    input  logic [DATA_W-1:0] lo_i,
    // Decode-stage read ports
    input  logic              re1,
    input  logic [ADDR_W-1:0] raddr1,
    output logic [DATA_W-1:0] rdata1,
    input  logic              re2,
    input  logic [ADDR_W-1:0] raddr2,
    output logic [DATA_W-1:0] rdata2,
    // Execute-stage HI/LO read
    output logic [DATA_W-1:0] hi_o,
    output logic [DATA_W-1:0] lo_o
);

    localparam int NREGS = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(NOP_REG_ADDR);
    localparam logic [DATA_W-1:0] ZERO_DATA = DATA_W'(ZERO_WORD);

    logic [DATA_W-1:0] regs_q [NREGS];
    logic              gpr_wr_d;

    // Write qualifier: writes to $zero are dropped at the source.
    always_comb begin
        gpr_wr_d = 1'b0;
        if (we == WRITE_ENABLE && waddr != ZERO_ADDR) begin
            gpr_wr_d = 1'b1;
        end
    end

    // GPR array: synchronous clear of every entry, else single-port write.
    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= ZERO_DATA;
            end
        end else if (gpr_wr_d) begin
            regs_q[waddr] <= wdata;
        end
    end

    // Read port 1: reset, $zero, bypass, array, then disabled, in that order.
    always_comb begin
        rdata1 = ZERO_DATA;
        if (rst == RST_ENABLE) begin
            rdata1 = ZERO_DATA;
        end else if (raddr1 == ZERO_ADDR) begin
            rdata1 = ZERO_DATA;
        end else if (re1 == READ_ENABLE && we == WRITE_ENABLE && raddr1 == waddr) begin
            rdata1 = wdata;
        end else if (re1 == READ_ENABLE) begin
            rdata1 = regs_q[raddr1];
        end
    end

    // Read port 2: same priority chain, fully independent of port 1.
    always_comb begin
        rdata2 = ZERO_DATA;
        if (rst == RST_ENABLE) begin
            rdata2 = ZERO_DATA;
        end else if (raddr2 == ZERO_ADDR) begin
            rdata2 = ZERO_DATA;
        end else if (re2 == READ_ENABLE && we == WRITE_ENABLE && raddr2 == waddr) begin
            rdata2 = wdata;
        end else if (re2 == READ_ENABLE) begin
            rdata2 = regs_q[raddr2];
        end
    end

    hilo_reg #(
        .DATA_W (DATA_W)
    ) u_hilo_reg (
        .clk   (clk),
        .rst   (rst),
        .whilo (whilo),
        .hi_i  (hi_i),
        .lo_i  (lo_i),
        .hi_o  (hi_o),
        .lo_o  (lo_o)
    );

endmodule : wb_regfile_hilo

// File: tb/tb_wb_regfile_hilo.sv
// Directed bench for the write-back register file and HI/LO pair.
// Inputs change 1 time unit after a rising edge; outputs are sampled one
// further unit later, well clear of the next edge.
module tb_wb_regfile_hilo;

    localparam int DW = 32;
    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          rst;
    logic          we;
    logic [AW-1:0] waddr;
    logic [DW-1:0] wdata;
    logic          whilo;
    logic [DW-1:0] hi_i;
    logic [DW-1:0] lo_i;
    logic          re1;
    logic [AW-1:0] raddr1;
    logic [DW-1:0] rdata1;
    logic          re2;
    logic [AW-1:0] raddr2;
    logic [DW-1:0] rdata2;
    logic [DW-1:0] hi_o;
    logic [DW-1:0] lo_o;

    int checks = 0;
    int errors = 0;

    // Clock
    always #5 clk = ~clk;

    wb_regfile_hilo #(
        .DATA_W (DW),
        .ADDR_W (AW)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .we     (we),
        .waddr  (waddr),
        .wdata  (wdata),
        .whilo  (whilo),
        .hi_i   (hi_i),
        .lo_i   (lo_i),
        .re1    (re1),
        .raddr1 (raddr1),
        .rdata1 (rdata1),
        .re2    (re2),
        .raddr2 (raddr2),
        .rdata2 (rdata2),
        .hi_o   (hi_o),
        .lo_o   (lo_o)
    );

    task automatic idle();
        we = 1'b0; waddr = '0; wdata = '0;
        whilo = 1'b0; hi_i = '0; lo_i = '0;
        re1 = 1'b0; raddr1 = '0; re2 = 1'b0; raddr2 = '0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; idle();
        re1 = 1'b1; raddr1 = 5'd5; re2 = 1'b1; raddr2 = 5'd5;
        step(); step();
        #1;
        checks++; if (rdata1 !== 32'h0) begin errors++; $display("FAIL rst_init_rdata1 got %h exp %h", rdata1, 32'h0); end
        checks++; if (rdata2 !== 32'h0) begin errors++; $display("FAIL rst_init_rdata2 got %h exp %h", rdata2, 32'h0); end
        checks++; if (hi_o !== 32'h0) begin errors++; $display("FAIL rst_init_hi got %h exp %h", hi_o, 32'h0); end
        checks++; if (lo_o !== 32'h0) begin errors++; $display("FAIL rst_init_lo got %h exp %h", lo_o, 32'h0); end
        // Write r5 out of reset and confirm it landed.
        rst = 1'b0; we = 1'b1; waddr = 5'd5; wdata = 32'hDEADBEEF;
        step();
        we = 1'b0;
        #1;
        checks++; if (rdata1 !== 32'hDEADBEEF) begin errors++; $display("FAIL rst_pre_r5 got %h exp %h", rdata1, 32'hDEADBEEF); end
        // Hold reset for two cycles; a HI/LO write during reset must be lost.
        rst = 1'b1; whilo = 1'b1; hi_i = 32'h9; lo_i = 32'h9;
        #1;
        checks++; if (rdata1 !== 32'h0) begin errors++; $display("FAIL rst_during_r5 got %h exp %h", rdata1, 32'h0); end
        checks++; if (hi_o !== 32'h0) begin errors++; $display("FAIL rst_during_hi got %h exp %h", hi_o, 32'h0); end
        step(); step();
        rst = 1'b0; whilo = 1'b0; hi_i = '0; lo_i = '0;
        #1;
        checks++; if (rdata1 !== 32'h0) begin errors++; $display("FAIL rst_post_r5 got %h exp %h", rdata1, 32'h0); end
        checks++; if (hi_o !== 32'h0) begin errors++; $display("FAIL rst_post_hi got %h exp %h", hi_o, 32'h0); end
        checks++; if (lo_o !== 32'h0) begin errors++; $display("FAIL rst_post_lo got %h exp %h", lo_o, 32'h0); end
    endtask

    task automatic test_basic();
        step(); idle();
        we = 1'b1; waddr = 5'd3; wdata = 32'h12345678;
        step(); idle();
        re1 = 1'b1; raddr1 = 5'd3; re2 = 1'b1; raddr2 = 5'd4;
        #1;
        checks++; if (rdata1 !== 32'h12345678) begin errors++; $display("FAIL basic_r3 got %h exp %h", rdata1, 32'h12345678); end
        checks++; if (rdata2 !== 32'h0) begin errors++; $display("FAIL basic_r4 got %h exp %h", rdata2, 32'h0); end
        re1 = 1'b0;
        #1;
        checks++; if (rdata1 !== 32'h0) begin errors++; $display("FAIL basic_re1_off got %h exp %h", rdata1, 32'h0); end
    endtask

    task automatic test_bypass();
        step(); idle();
        we = 1'b1; waddr = 5'd7; wdata = 32'hA5A5A5A5;
        re1 = 1'b1; raddr1 = 5'd7; re2 = 1'b1; raddr2 = 5'd7;
        #1;
        checks++; if (rdata1 !== 32'hA5A5A5A5) begin errors++; $display("FAIL byp_p1 got %h exp %h", rdata1, 32'hA5A5A5A5); end
        checks++; if (rdata2 !== 32'hA5A5A5A5) begin errors++; $display("FAIL byp_p2 got %h exp %h", rdata2, 32'hA5A5A5A5); end
        re1 = 1'b0;
        #1;
        checks++; if (rdata1 !== 32'h0) begin errors++; $display("FAIL byp_re1_off got %h exp %h", rdata1, 32'h0); end
        checks++; if (rdata2 !== 32'hA5A5A5A5) begin errors++; $display("FAIL byp_p2_alone got %h exp %h", rdata2, 32'hA5A5A5A5); end
        // Bypass must override an older stored value.
        step(); idle();
        we = 1'b1; waddr = 5'd3; wdata = 32'hCAFEF00D;
        re1 = 1'b1; raddr1 = 5'd7; re2 = 1'b1; raddr2 = 5'd3;
        #1;
        checks++; if (rdata1 !== 32'hA5A5A5A5) begin errors++; $display("FAIL byp_r7_stored got %h exp %h", rdata1, 32'hA5A5A5A5); end
        checks++; if (rdata2 !== 32'hCAFEF00D) begin errors++; $display("FAIL byp_r3_new got %h exp %h", rdata2, 32'hCAFEF00D); end
        step();
        we = 1'b0;
        #1;
        checks++; if (rdata2 !== 32'hCAFEF00D) begin errors++; $display("FAIL byp_r3_kept got %h exp %h", rdata2, 32'hCAFEF00D); end
    endtask

    task automatic test_zero();
        step(); idle();
        we = 1'b1; waddr = 5'd0; wdata = 32'hFFFFFFFF;
        re1 = 1'b1; raddr1 = 5'd0; re2 = 1'b1; raddr2 = 5'd0;
        #1;
        checks++; if (rdata1 !== 32'h0) begin errors++; $display("FAIL zero_same_p1 got %h exp %h", rdata1, 32'h0); end
        checks++; if (rdata2 !== 32'h0) begin errors++; $display("FAIL zero_same_p2 got %h exp %h", rdata2, 32'h0); end
        step();
        we = 1'b0;
        #1;
        checks++; if (rdata1 !== 32'h0) begin errors++; $display("FAIL zero_next_p1 got %h exp %h", rdata1, 32'h0); end
        checks++; if (rdata2 !== 32'h0) begin errors++; $display("FAIL zero_next_p2 got %h exp %h", rdata2, 32'h0); end
    endtask

    task automatic test_hilo();
        step(); idle();
        whilo = 1'b1; hi_i = 32'h1; lo_i = 32'h2;
        #1;
        checks++; if (hi_o !== 32'h1) begin errors++; $display("FAIL hilo_byp_hi got %h exp %h", hi_o, 32'h1); end
        checks++; if (lo_o !== 32'h2) begin errors++; $display("FAIL hilo_byp_lo got %h exp %h", lo_o, 32'h2); end
        step();
        whilo = 1'b0; hi_i = 32'hDEAD; lo_i = 32'hBEEF;
        step();
        checks++; if (hi_o !== 32'h1) begin errors++; $display("FAIL hilo_hold_hi got %h exp %h", hi_o, 32'h1); end
        checks++; if (lo_o !== 32'h2) begin errors++; $display("FAIL hilo_hold_lo got %h exp %h", lo_o, 32'h2); end
        whilo = 1'b1; hi_i = 32'h3; lo_i = 32'h4;
        #1;
        checks++; if (hi_o !== 32'h3) begin errors++; $display("FAIL hilo_upd_hi got %h exp %h", hi_o, 32'h3); end
        checks++; if (lo_o !== 32'h4) begin errors++; $display("FAIL hilo_upd_lo got %h exp %h", lo_o, 32'h4); end
        // GPR and HI/LO writes in the same cycle both commit.
        step(); idle();
        we = 1'b1; waddr = 5'd9; wdata = 32'h99; whilo = 1'b1; hi_i = 32'h5; lo_i = 32'h6;
        step(); idle();
        re2 = 1'b1; raddr2 = 5'd9;
        #1;
        checks++; if (rdata2 !== 32'h99) begin errors++; $display("FAIL both_gpr got %h exp %h", rdata2, 32'h99); end
        checks++; if (hi_o !== 32'h5) begin errors++; $display("FAIL both_hi got %h exp %h", hi_o, 32'h5); end
        checks++; if (lo_o !== 32'h6) begin errors++; $display("FAIL both_lo got %h exp %h", lo_o, 32'h6); end
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] vals [4];
        vals[0] = 32'h0000_1111; vals[1] = 32'h2222_0000;
        vals[2] = 32'h3333_3333; vals[3] = 32'h8000_0001;
        step(); idle();
        for (int k = 0; k < 4; k++) begin
            we = 1'b1; waddr = AW'(10 + k); wdata = vals[k];
            re2 = 1'b1; raddr2 = AW'(10 + k);
            re1 = (k > 0); raddr1 = AW'(9 + k);
            #1;
            checks++; if (rdata2 !== vals[k]) begin errors++; $display("FAIL b2b_byp k=%0d got %h exp %h", k, rdata2, vals[k]); end
            if (k > 0) begin
                checks++; if (rdata1 !== vals[k-1]) begin errors++; $display("FAIL b2b_prev k=%0d got %h exp %h", k, rdata1, vals[k-1]); end
            end
            step();
        end
        idle();
        re1 = 1'b1; re2 = 1'b1;
        for (int k = 0; k < 4; k++) begin
            raddr1 = AW'(10 + k); raddr2 = AW'(13 - k);
            #1;
            checks++; if (rdata1 !== vals[k]) begin errors++; $display("FAIL b2b_rd1 k=%0d got %h exp %h", k, rdata1, vals[k]); end
            checks++; if (rdata2 !== vals[3-k]) begin errors++; $display("FAIL b2b_rd2 k=%0d got %h exp %h", k, rdata2, vals[3-k]); end
        end
    endtask

    task automatic test_rst_simul();
        step(); idle();
        rst = 1'b1;
        we = 1'b1; waddr = 5'd31; wdata = 32'h55;
        whilo = 1'b1; hi_i = 32'h77; lo_i = 32'h88;
        re1 = 1'b1; raddr1 = 5'd31; re2 = 1'b1; raddr2 = 5'd3;
        #1;
        checks++; if (rdata1 !== 32'h0) begin errors++; $display("FAIL rsim_in_p1 got %h exp %h", rdata1, 32'h0); end
        checks++; if (rdata2 !== 32'h0) begin errors++; $display("FAIL rsim_in_p2 got %h exp %h", rdata2, 32'h0); end
        checks++; if (hi_o !== 32'h0) begin errors++; $display("FAIL rsim_in_hi got %h exp %h", hi_o, 32'h0); end
        checks++; if (lo_o !== 32'h0) begin errors++; $display("FAIL rsim_in_lo got %h exp %h", lo_o, 32'h0); end
        step();
        rst = 1'b0; idle();
        re1 = 1'b1; raddr1 = 5'd31; re2 = 1'b1; raddr2 = 5'd3;
        #1;
        checks++; if (rdata1 !== 32'h0) begin errors++; $display("FAIL rsim_post_r31 got %h exp %h", rdata1, 32'h0); end
        checks++; if (rdata2 !== 32'h0) begin errors++; $display("FAIL rsim_post_r3 got %h exp %h", rdata2, 32'h0); end
        checks++; if (hi_o !== 32'h0) begin errors++; $display("FAIL rsim_post_hi got %h exp %h", hi_o, 32'h0); end
        checks++; if (lo_o !== 32'h0) begin errors++; $display("FAIL rsim_post_lo got %h exp %h", lo_o, 32'h0); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_bypass();
        test_zero();
        test_hilo();
        test_back_to_back();
        test_rst_simul();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_wb_regfile_hilo
